alu_mdu: RTL and testbench

Sequential, parametrised execute unit for the RV32 core: a superset of the single-cycle ALU that adds the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative multiply/divide datapath. The unit sits in the execute stage between operand select and writeback/branch logic. It accepts one operation at a time through a valid/ready handshake and returns a registered result with a one-cycle `out_valid` pulse. Base operations take 1 cycle; M operations take XLEN+1 cycles.

---
 rtl/alu_mdu_if.sv | 26 ++
 rtl/alu_mdu.sv | 218 +++++++++++++++++++++
 tb/tb_alu_mdu.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request (opcode/operands, valid/ready) and registered result bus.
// master: in_valid, opcode, funct3, funct7, in1, in2 -> slave: in_ready, out_valid, out, zero.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic [XLEN-1:0] out;
  logic            zero;

  modport master (
    output in_valid, opcode, funct3, funct7, in1, in2,
    input  in_ready, out_valid, out, zero
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, in1, in2,
    output in_ready, out_valid, out, zero
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: RV32 execute unit, 1-cycle base ALU plus iterative M-extension.
// Ports: clk, rst_n (sync, active-low), bus (alu_mdu_if.slave).
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mdu_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0]  CNT_MAX = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_UPC  = 7'b0010111;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic [1:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [XLEN-1:0]     out_q, out_d;
  logic                zero_q, zero_d;
  logic                vld_q, vld_d;

  logic [XLEN-1:0] a, b, sra, alu_out;
  logic [SHW-1:0]  sh;
  logic            alu_zero, lt_s, lt_u;

  assign a    = bus.in1;
  assign b    = bus.in2;
  assign sh   = b[SHW-1:0];
  assign sra  = $signed(a) >>> sh;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    alu_out  = '0;
    alu_zero = 1'b0;
    unique case (bus.opcode)
      OP_R, OP_I: begin
        unique case (bus.funct3)
          3'b000: alu_out = (bus.opcode == OP_R && bus.funct7[5])
                            ? a - b : a + b;
          3'b001: alu_out = a << sh;
          3'b010: alu_out = {{(XLEN-1){1'b0}}, lt_s};
          3'b011: alu_out = {{(XLEN-1){1'b0}}, lt_u};
          3'b100: alu_out = a ^ b;
          3'b101: alu_out = bus.funct7[5] ? sra : a >> sh;
          3'b110: alu_out = a | b;
          3'b111: alu_out = a & b;
        endcase
      end
      OP_B: begin
        case (bus.funct3)
          3'b000:  alu_zero = (a == b);
          3'b001:  alu_zero = (a != b);
          3'b100:  alu_zero = lt_s;
          3'b101:  alu_zero = !lt_s;
          3'b110:  alu_zero = lt_u;
          3'b111:  alu_zero = !lt_u;
          default: alu_zero = 1'b0;
        endcase
      end
      OP_J, OP_JALR: begin
        alu_out  = a + b;
        alu_zero = 1'b1;
      end
      OP_U:         alu_out = b << 12;
      OP_UPC:       alu_out = a + (b << 12);
      OP_LD, OP_ST: alu_out = a + b;
      default:      alu_out = '0;
    endcase
  end

  // M-op decode and operand magnitudes
  logic            is_m, d_sgn, m_as, m_bs, div0, ovf;
  logic [XLEN-1:0] m_amag, m_bmag, d_amag, d_bmag, sp_res;

  assign is_m   = (bus.opcode == OP_R) && (bus.funct7 == 7'b0000001);
  assign d_sgn  = !bus.funct3[0];
  assign m_as   = (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
  assign m_bs   = (bus.funct3[1:0] == 2'b01);
  assign m_amag = (m_as && a[XLEN-1]) ? -a : a;
  assign m_bmag = (m_bs && b[XLEN-1]) ? -b : b;
  assign d_amag = (d_sgn && a[XLEN-1]) ? -a : a;
  assign d_bmag = (d_sgn && b[XLEN-1]) ? -b : b;
  assign div0   = (b == '0);
  assign ovf    = d_sgn && (a == MIN_NEG) && (b == '1);
  assign sp_res = div0 ? (bus.funct3[1] ? a : '1)
                       : (bus.funct3[1] ? '0 : a);

  // one shift-add step: multiplier in acc low half, multiplicand in dvs
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
  assign prod    = neg_q ? -mul_nxt : mul_nxt;
  assign mul_res = (f3_q == 2'b00) ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];

  // one restoring step: remainder in acc high half, quotient shifts in low
  logic [XLEN:0]     div_rsh, div_dif;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   quo, rem, div_res;

  assign div_rsh = acc_q[2*XLEN-1:XLEN-1];
  assign div_dif = div_rsh - {1'b0, dvs_q};
  assign div_nxt = div_dif[XLEN]
    ? {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
    : {div_dif[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign quo     = div_nxt[XLEN-1:0];
  assign rem     = div_nxt[2*XLEN-1:XLEN];
  assign div_res = f3_q[1] ? (rneg_q ? -rem : rem)
                           : (neg_q ? -quo : quo);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    out_d   = out_q;
    zero_d  = zero_q;
    vld_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          f3_d  = bus.funct3[1:0];
          cnt_d = '0;
          if (is_m && !bus.funct3[2]) begin
            state_d = S_MUL;
            acc_d   = {{XLEN{1'b0}}, m_bmag};
            dvs_d   = m_amag;
            neg_d   = (m_as && a[XLEN-1]) ^ (m_bs && b[XLEN-1]);
          end else if (is_m && (div0 || ovf)) begin
            state_d = S_EXEC;
            out_d   = sp_res;
            zero_d  = 1'b0;
            vld_d   = 1'b1;
          end else if (is_m) begin
            state_d = S_DIV;
            acc_d   = {{XLEN{1'b0}}, d_amag};
            dvs_d   = d_bmag;
            neg_d   = d_sgn && (a[XLEN-1] ^ b[XLEN-1]);
            rneg_d  = d_sgn && a[XLEN-1];
          end else begin
            state_d = S_EXEC;
            out_d   = alu_out;
            zero_d  = alu_zero;
            vld_d   = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_nxt : div_nxt;
        cnt_d = cnt_q + SHW'(1);
        // last step: load the result so it is visible during DONE
        if (cnt_q == CNT_MAX) begin
          state_d = S_DONE;
          out_d   = (state_q == S_MUL) ? mul_res : div_res;
          zero_d  = 1'b0;
          vld_d   = 1'b1;
        end
      end
      S_EXEC, S_DONE: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = vld_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed + random checks of alu_mdu against an arithmetic model.
// Drives inputs on negedge, samples outputs on negedge.
module tb_alu_mdu;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_mdu_if #(.XLEN(32)) bus ();

  alu_mdu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: RV32 semantics from plain 64-bit arithmetic
  function automatic void ref_op(input req_t q, output logic [31:0] r,
                                 output logic z, output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int si;
    sa = longint'($signed(q.a));
    sb = longint'($signed(q.b));
    ua = longint'({32'h0, q.a});
    ub = longint'({32'h0, q.b});
    si = $signed(q.a);
    r = 32'h0;
    z = 1'b0;
    lat = 1;
    if (q.op == 7'h33 && q.f7 == 7'h01) begin
      if (!q.f3[2]) begin
        lat = 33;
        case (q.f3[1:0])
          2'd0: begin p = ua * ub; r = p[31:0]; end
          2'd1: begin p = sa * sb; r = p[63:32]; end
          2'd2: begin p = sa * ub; r = p[63:32]; end
          default: begin p = ua * ub; r = p[63:32]; end
        endcase
      end else if (q.b == 32'h0) begin
        r = q.f3[1] ? q.a : 32'hFFFF_FFFF;
      end else if (!q.f3[0] && q.a == 32'h8000_0000
                   && q.b == 32'hFFFF_FFFF) begin
        r = q.f3[1] ? 32'h0 : q.a;
      end else begin
        lat = 33;
        if (!q.f3[0]) p = q.f3[1] ? 64'(sa % sb) : 64'(sa / sb);
        else          p = q.f3[1] ? 64'(ua % ub) : 64'(ua / ub);
        r = p[31:0];
      end
    end else begin
      case (q.op)
        7'h33, 7'h13: begin
          case (q.f3)
            3'd0: r = (q.op == 7'h33 && q.f7[5]) ? q.a - q.b : q.a + q.b;
            3'd1: r = q.a << q.b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = q.a ^ q.b;
            3'd5: r = q.f7[5] ? 32'(si >>> q.b[4:0]) : q.a >> q.b[4:0];
            3'd6: r = q.a | q.b;
            default: r = q.a & q.b;
          endcase
        end
        7'h63: begin
          case (q.f3)
            3'd0: z = (q.a == q.b);
            3'd1: z = (q.a != q.b);
            3'd4: z = (sa < sb);
            3'd5: z = (sa >= sb);
            3'd6: z = (ua < ub);
            3'd7: z = (ua >= ub);
            default: z = 1'b0;
          endcase
        end
        7'h6F, 7'h67: begin r = q.a + q.b; z = 1'b1; end
        7'h37: r = q.b << 12;
        7'h17: r = q.a + (q.b << 12);
        7'h03, 7'h23: r = q.a + q.b;
        default: r = 32'h0;
      endcase
    end
  endfunction

  task automatic drive(input req_t q);
    bus.opcode = q.op;
    bus.funct3 = q.f3;
    bus.funct7 = q.f7;
    bus.in1    = q.a;
    bus.in2    = q.b;
  endtask

  task automatic run_op(input string tag, input req_t q);
    logic [31:0] er;
    logic ez;
    int el, k, g;
    ref_op(q, er, ez, el);
    @(negedge clk);
    g = 0;
    while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
    chk({tag, "/ready"}, 32'(bus.in_ready), 32'd1);
    drive(q);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in1 = $urandom;
    bus.in2 = $urandom;
    bus.funct3 = 3'($urandom);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.out_valid && k < 100);
    chk({tag, "/lat"}, 32'(k), 32'(el));
    chk({tag, "/out"}, bus.out, er);
    chk({tag, "/zero"}, 32'(bus.zero), 32'(ez));
    @(negedge clk);
    chk({tag, "/pulse"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "/hold"}, bus.out, er);
  endtask

  function automatic req_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] a,
                              input logic [31:0] b);
    req_t q;
    q.op = op; q.f3 = f3; q.f7 = f7; q.a = a; q.b = b;
    return q;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [6];
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
               32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  function automatic req_t rand_req();
    req_t q;
    logic [6:0] ops [6];
    ops = '{7'h6F, 7'h67, 7'h37, 7'h17, 7'h03, 7'h23};
    q.a  = pick();
    q.b  = pick();
    q.f3 = 3'($urandom);
    q.f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 9))
      0: q.op = 7'h33;
      1: q.op = 7'h13;
      2: q.op = 7'h63;
      3, 4: q.op = ops[$urandom_range(0, 5)];
      5: q.op = $urandom_range(0, 1) ? 7'h7F : 7'h0B;
      default: begin q.op = 7'h33; q.f7 = 7'h01; end
    endcase
    return q;
  endfunction

  initial begin
    req_t hs [5];
    logic [31:0] exp_r [$];
    logic exp_z [$];
    int acc_c [$];
    int hs_lat [5];
    logic [31:0] er;
    logic ez;
    int el, i, got, seen;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    drive(mk(7'h0, 3'h0, 7'h0, 32'h0, 32'h0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/ready", 32'(bus.in_ready), 32'd1);
    chk("rst/valid", 32'(bus.out_valid), 32'd0);
    chk("rst/out", bus.out, 32'h0);
    chk("rst/zero", 32'(bus.zero), 32'd0);

    // reset in the middle of a multiply
    run_op("pre_add", mk(7'h33, 3'd0, 7'h00, 32'd1, 32'd2));
    drive(mk(7'h33, 3'd0, 7'h01, 32'd3, 32'd5));
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst/out", bus.out, 32'h0);
    chk("mrst/ready", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("mrst/nopulse", 32'(seen), 32'd0);

    // directed base, M, branch and jump cases
    run_op("sub", mk(7'h33, 3'd0, 7'h20, 32'd5, 32'd7));
    run_op("addi_f7", mk(7'h13, 3'd0, 7'h20, 32'd5, 32'd7));
    run_op("sra", mk(7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'h21));
    run_op("mulh", mk(7'h33, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    run_op("mulhu", mk(7'h33, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    run_op("mulhsu", mk(7'h33, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'd2));
    run_op("div", mk(7'h33, 3'd4, 7'h01, -32'sd7, 32'd2));
    run_op("rem", mk(7'h33, 3'd6, 7'h01, -32'sd7, 32'd2));
    run_op("divu0", mk(7'h33, 3'd5, 7'h01, 32'd7, 32'd0));
    run_op("rem_ovf", mk(7'h33, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF));
    run_op("blt", mk(7'h63, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1));
    run_op("bltu", mk(7'h63, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1));
    run_op("jal", mk(7'h6F, 3'd0, 7'h00, 32'h100, 32'd8));

    // spot-check the model against the literal expected values
    ref_op(mk(7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'h21), er, ez, el);
    chk("model/sra", er, 32'hC000_0000);
    ref_op(mk(7'h33, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), er, ez, el);
    chk("model/mulhu", er, 32'hFFFF_FFFE);

    // randomized operations
    for (int n = 0; n < 80; n++) run_op("rand", rand_req());

    // handshake: in_valid held high, back-to-back ops
    hs[0] = mk(7'h33, 3'd0, 7'h00, 32'd10, 32'd20);
    hs[1] = mk(7'h33, 3'd4, 7'h00, 32'hF0F0, 32'h0FF0);
    hs[2] = mk(7'h13, 3'd3, 7'h00, 32'd1, 32'd2);
    hs[3] = mk(7'h33, 3'd0, 7'h01, 32'd1234, 32'd5678);
    hs[4] = mk(7'h33, 3'd0, 7'h20, 32'd3, 32'd9);
    i = 0;
    got = 0;
    for (int c = 0; c < 300 && got < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (exp_r.size() == 0) begin
          chk("hs/extra", 32'd1, 32'd0);
        end else begin
          chk("hs/out", bus.out, exp_r.pop_front());
          chk("hs/zero", 32'(bus.zero), 32'(exp_z.pop_front()));
        end
        got++;
      end
      if (i < 5) begin
        drive(hs[i]);
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          ref_op(hs[i], er, ez, el);
          exp_r.push_back(er);
          exp_z.push_back(ez);
          hs_lat[i] = el;
          acc_c.push_back(c);
          i++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("hs/pulses", 32'(got), 32'd5);
    chk("hs/accepts", 32'(acc_c.size()), 32'd5);
    for (int k = 1; k < acc_c.size(); k++)
      chk("hs/gap", 32'(acc_c[k] - acc_c[k-1]), 32'(hs_lat[k-1] + 1));
    repeat (3) @(negedge clk);
    chk("hs/quiet", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
